// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - pipeline hazard stall, interrupt flush/redirect sequencer and mult/div busy tracker
// Optional multiply/divide unit tracking enabled by HAZARD_SCHED_MD_UNIT_EN.
module hazard_sched (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] A1_D,
    input  logic [4:0] A2_D,
    input  logic [1:0] Tuse_rs,
    input  logic [1:0] Tuse_rt,
    input  logic       use_rs,
    input  logic       use_rt,
    input  logic [4:0] WriteAddr_E,
    input  logic [4:0] WriteAddr_M,
    input  logic [1:0] Tnew_E,
    input  logic [1:0] Tnew_M,
    input  logic       md_start,
    input  logic       md_op,
    input  logic       md_use_D,
    input  logic       int_req,
    output logic       stall,
    output logic       flush_all,
    output logic       redirect,
    output logic       md_busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   flush_all_q;
    logic   redirect_q;
    logic   rs_hit;
    logic   rt_hit;
    logic   md_hit;

    // A producer only hazards when its result is still further away than the consumer's need.
    assign rs_hit = use_rs && (A1_D != 5'd0) &&
                    (((A1_D == WriteAddr_E) && (Tnew_E > Tuse_rs)) ||
                     ((A1_D == WriteAddr_M) && (Tnew_M > Tuse_rs)));
    assign rt_hit = use_rt && (A2_D != 5'd0) &&
                    (((A2_D == WriteAddr_E) && (Tnew_E > Tuse_rt)) ||
                     ((A2_D == WriteAddr_M) && (Tnew_M > Tuse_rt)));

    assign stall = (rs_hit || rt_hit || md_hit) && (state_q == IDLE) && reset;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (int_req) state_d = FLUSH;
            FLUSH:    state_d = REDIRECT;
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            flush_all_q <= 1'b0;
            redirect_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_all_q <= (state_d == FLUSH);
            redirect_q  <= (state_d == REDIRECT);
        end
    end

    assign flush_all = flush_all_q;
    assign redirect  = redirect_q;

`ifdef HAZARD_SCHED_MD_UNIT_EN
    logic [3:0] md_cnt_q, md_cnt_d;
    logic       md_busy_q;

    // A running operation runs to completion; a new start is only accepted when idle.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_cnt_q != 4'd0)
            md_cnt_d = md_cnt_q - 4'd1;
        else if (md_start)
            md_cnt_d = md_op ? 4'd10 : 4'd5;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            md_cnt_q  <= 4'd0;
            md_busy_q <= 1'b0;
        end else begin
            md_cnt_q  <= md_cnt_d;
            md_busy_q <= (md_cnt_d != 4'd0);
        end
    end

    assign md_busy = md_busy_q;
    assign md_hit  = md_use_D && (md_busy_q || md_start);
`else
    logic unused_md;

    assign unused_md = ^{md_start, md_op, md_use_D};
    assign md_busy   = 1'b0;
    assign md_hit    = 1'b0;
`endif

endmodule

// File: doc/hazard_sched.md
HAZARD_SCHED -- requirements
Module: hazard_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset (reset==0 sampled at posedge resets).
REQ-003 SHALL have inputs A1_D, A2_D, 5 bits each: rs and rt read addresses of the instruction in D.
REQ-004 SHALL have inputs Tuse_rs, Tuse_rt, 2 bits each, plus use_rs and use_rt, 1 bit each: cycles until the D instruction consumes each operand, and whether it reads it at all.
REQ-005 SHALL have inputs WriteAddr_E, WriteAddr_M, 5 bits each, and Tnew_E, Tnew_M, 2 bits each: destination register and remaining cycles-to-result of the E and M occupants, with Tnew_M already decremented by the E/M register.
REQ-006 SHALL have inputs md_start (1 bit: E instruction starts mult/div this cycle), md_op (1 bit: 0=mult, 1=div) and md_use_D (1 bit: D instruction is mult/div/mfhi/mflo/mthi/mtlo).
REQ-007 SHALL have input int_req, 1 bit: interrupt or exception request from CP0, level-sensitive.
REQ-008 SHALL have outputs stall (1 bit: freeze PC and F/D, bubble D/E), flush_all (1 bit: drives the Interrupt input of every pipeline register), redirect (1 bit: PC select to handler 0x00004180) and md_busy (1 bit).

Function
REQ-009 SHALL compute rs_hit = use_rs && A1_D!=0 && ((A1_D==WriteAddr_E && Tnew_E>Tuse_rs) || (A1_D==WriteAddr_M && Tnew_M>Tuse_rs)), with rt_hit defined identically on A2_D, use_rt, Tuse_rt.
REQ-010 SHALL compute md_hit = md_use_D && (md_busy || md_start).
REQ-011 SHALL drive stall = (rs_hit || rt_hit || md_hit) && state==IDLE && reset==1, combinationally in the same cycle.
REQ-012 SHALL implement a 3-state FSM: IDLE, FLUSH, REDIRECT.
REQ-013 FSM transitions: IDLE->FLUSH when int_req==1; FLUSH->REDIRECT unconditionally; REDIRECT->IDLE unconditionally.
REQ-014 SHALL register flush_all=1 exactly in FLUSH and redirect=1 exactly in REDIRECT, each 1 cycle wide, both 0 in IDLE.
REQ-015 SHALL ignore int_req in FLUSH and REDIRECT; int_req still high on return to IDLE starts a new sequence the next cycle.
REQ-016 When int_req and a hazard coincide in IDLE, the interrupt SHALL win: stall is 0 from the cycle the FSM leaves IDLE.
REQ-017 SHALL hold a 4-bit md counter: md_start in a cycle with counter==0 loads 5 (mult) or 10 (div); a nonzero counter decrements by 1 per cycle.
REQ-018 SHALL drive md_busy = (counter!=0), registered.
REQ-019 SHALL ignore md_start while the counter is nonzero; the counter is not reloaded.
REQ-020 SHALL let a running mult/div finish during FLUSH/REDIRECT; flush_all does not clear the counter.
REQ-021 SHALL treat register 0 as hazard-free regardless of Tnew.

Reset
REQ-022 On posedge clk with reset==0: FSM=IDLE, md counter=0, flush_all=0, redirect=0, md_busy=0.
REQ-023 While reset==0, stall SHALL be 0.
REQ-024 Reset mid-sequence (FLUSH or REDIRECT) or mid-divide SHALL abort the operation and return to the REQ-022 state on that edge.

Configuration
REQ-025 Macro HAZARD_SCHED_MD_UNIT_EN: when defined, REQ-010/017-020 are implemented as specified.
REQ-026 Without HAZARD_SCHED_MD_UNIT_EN: no md counter; md_busy is constant 0, md_hit is 0, and md_start/md_op/md_use_D are unused.

Verification
REQ-027 Load-use: WriteAddr_E=5, Tnew_E=2, A1_D=5, use_rs=1, Tuse_rs=0 -> stall=1; next cycle Tnew_M=1, WriteAddr_M=5, E bubbled -> stall=1; following cycle -> stall=0.
REQ-028 Zero register: A1_D=0, WriteAddr_E=0, Tnew_E=2, use_rs=1, Tuse_rs=0 -> stall=0.
REQ-029 Divide: md_start=1, md_op=1 -> md_busy=1 for exactly 10 cycles; mflo in D (md_use_D=1) -> stall=1 throughout; second md_start at cycle 3 -> no reload.
REQ-030 Interrupt during stall: hazard held, int_req pulsed 1 cycle -> next cycle flush_all=1, stall=0; then redirect=1; then IDLE with stall re-evaluated.
REQ-031 Reset in FLUSH: reset=0 at the FLUSH cycle -> next cycle flush_all=0, redirect=0, md_busy=0.
REQ-032 Build without HAZARD_SCHED_MD_UNIT_EN: md_start=1, md_use_D=1 -> md_busy=0, stall=0.
